// File: rtl/alu_sequencer.sv
// Drives an external N-bit ALU word by word, LSW first, so that one wide Add/Sub/logic
// operation on WORDS-word operands produces a full-width result and aggregated flags.
module alu_sequencer #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [3:0]           op_i,
   input  logic [N*WORDS-1:0]   op_a_i,
   input  logic [N*WORDS-1:0]   op_b_i,
   input  logic                 carry_in_i,
   output logic [N-1:0]         alu_a_o,
   output logic [N-1:0]         alu_b_o,
   output logic [3:0]           alu_func_op_o,
   output logic [3:0]           alu_iflags_o,
   output logic                 alu_oe_o,
   input  logic [N-1:0]         alu_y_i,
   input  logic [3:0]           alu_flags_i,
   output logic [N*WORDS-1:0]   result_o,
   output logic [3:0]           flags_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SUBC = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;

   logic [1:0]         state_q, state_d;
   logic [3:0]         op_q;
   logic [N*WORDS-1:0] a_q, b_q;
   logic               cin_q;
   logic [IW-1:0]      idx_q;
   logic               carry_q;
   logic               zacc_q;
   logic               err_q;
   logic [N-1:0]       alu_a_q, alu_b_q;
   logic [3:0]         alu_func_q;
   logic               alu_cin_q;
   logic [N*WORDS-1:0] result_q;
   logic [3:0]         flags_q;

   logic               op_ok;
   logic [3:0]         issue_func;
   logic               issue_c;
   logic [N-1:0]       a_word [WORDS];
   logic [N-1:0]       b_word [WORDS];

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign a_word[gi] = a_q[gi*N +: N];
         assign b_word[gi] = b_q[gi*N +: N];
      end
   endgenerate

   assign op_ok = op_i inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR};

   // Sub becomes Subc after word 0; the ALU's C means "no borrow", hence the inversion.
   always_comb begin
      issue_func = op_q;
      issue_c    = 1'b0;
      case (op_q)
         OP_ADD: issue_c = (idx_q == '0) ? cin_q : carry_q;
         OP_SUB: begin
            if (idx_q != '0) begin
               issue_func = OP_SUBC;
               issue_c    = ~carry_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_i) state_d = op_ok ? S_ISSUE : S_FINISH;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = (idx_q == LAST_IDX) ? S_FINISH : S_ISSUE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         zacc_q     <= 1'b0;
         err_q      <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_func_q <= '0;
         alu_cin_q  <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  op_q   <= op_i;
                  a_q    <= op_a_i;
                  b_q    <= op_b_i;
                  cin_q  <= carry_in_i;
                  idx_q  <= '0;
                  zacc_q <= 1'b1;
                  err_q  <= ~op_ok;
               end
            end
            S_ISSUE: begin
               alu_a_q    <= a_word[idx_q];
               alu_b_q    <= b_word[idx_q];
               alu_func_q <= issue_func;
               alu_cin_q  <= issue_c;
            end
            S_CAPTURE: begin
               result_q[idx_q*N +: N] <= alu_y_i;
               carry_q <= alu_flags_i[1];
               zacc_q  <= zacc_q & alu_flags_i[0];
               idx_q   <= idx_q + 1'b1;
               // Flags land on entry to FINISH so they are valid alongside Done.
               if (idx_q == LAST_IDX)
                  flags_q <= {alu_flags_i[3:1], zacc_q & alu_flags_i[0]};
            end
            default: ;
         endcase
      end
   end

   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_func_op_o = alu_func_q;
   assign alu_iflags_o  = {2'b00, alu_cin_q, 1'b0};
   assign alu_oe_o      = (state_q != S_CAPTURE);
   assign result_o      = result_q;
   assign flags_o       = flags_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_FINISH);
   assign error_o       = (state_q == S_FINISH) && err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (N=8, WORDS=4) with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        carry_in = 1'b0;
   logic [7:0]  alu_a, alu_b, alu_y;
   logic [3:0]  alu_func, alu_iflags, alu_flags;
   logic        alu_oe;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        busy, done, error;

   int checks = 0;
   int errors = 0;

   int          lat, n_cap, extra_done;
   logic        got_err, busy_first;
   logic [3:0]  seq_func [8];
   logic        seq_cin [8];

   logic [8:0]  m_ext;
   logic [7:0]  m_y;
   logic        m_c, m_v;

   alu_sequencer #(.N(8), .WORDS(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .op_i          (op),
      .op_a_i        (op_a),
      .op_b_i        (op_b),
      .carry_in_i    (carry_in),
      .alu_a_o       (alu_a),
      .alu_b_o       (alu_b),
      .alu_func_op_o (alu_func),
      .alu_iflags_o  (alu_iflags),
      .alu_oe_o      (alu_oe),
      .alu_y_i       (alu_y),
      .alu_flags_i   (alu_flags),
      .result_o      (result),
      .flags_o       (flags),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error)
   );

   always #5 clk = ~clk;

   // External ALU: C is carry-out for Add and "no borrow" for Sub/Subc; bus reads 0 when disabled.
   always_comb begin
      m_ext = '0;
      m_y   = '0;
      m_c   = 1'b0;
      m_v   = 1'b0;
      case (alu_func)
         4'd0: begin
            m_ext = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_iflags[1]};
            m_y   = m_ext[7:0];
            m_c   = m_ext[8];
            m_v   = (alu_a[7] == alu_b[7]) && (m_y[7] != alu_a[7]);
         end
         4'd1, 4'd2: begin
            m_ext = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, (alu_func == 4'd2) & alu_iflags[1]};
            m_y   = m_ext[7:0];
            m_c   = ~m_ext[8];
            m_v   = (alu_a[7] != alu_b[7]) && (m_y[7] != alu_a[7]);
         end
         4'd3: m_y = alu_a & alu_b;
         4'd4: m_y = alu_a | alu_b;
         4'd5: m_y = ~alu_a;
         4'd6: m_y = alu_a ^ alu_b;
         default: ;
      endcase
      if (alu_oe) begin
         alu_y     = '0;
         alu_flags = '0;
      end else begin
         alu_y     = m_y;
         alu_flags = {m_v, m_y[7], m_c, (m_y == 8'd0)};
      end
   end

   // lat counts posedges from the Start sampling edge to the edge that samples Done high.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic poke);
      @(negedge clk);
      op = o; op_a = a; op_b = b; carry_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; n_cap = 0; got_err = 1'b0; extra_done = 0;
      busy_first = busy;
      for (int k = 0; k < 40; k++) begin
         if (!alu_oe) begin
            if (n_cap < 8) begin
               seq_func[n_cap] = alu_func;
               seq_cin[n_cap]  = alu_iflags[1];
            end
            n_cap++;
         end
         if (done) begin
            lat = k + 1;
            got_err = error;
            break;
         end
         if (poke && k == 3) begin
            op = 4'b0111; op_a = 32'hDEADBEEF; op_b = 32'h13572468; carry_in = 1'b1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done || error) extra_done++;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b%b expected 00", done, error); end
      checks++; if (alu_oe !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b expected 1", alu_oe); end
      checks++; if ({alu_a, alu_b, alu_func, alu_iflags} !== 24'd0) begin errors++; $display("FAIL reset_alu_drive: got %h expected 0", {alu_a, alu_b, alu_func, alu_iflags}); end
      checks++; if (result !== 32'd0 || flags !== 4'd0) begin errors++; $display("FAIL reset_result_flags: got %h/%b expected 0/0000", result, flags); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      run_op(4'b0000, 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      checks++; if (lat !== 9) begin errors++; $display("FAIL add_latency: got %0d expected 9", lat); end
      checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", busy_first); end
      checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL add_result: got %h expected 00000100", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b expected 0000", flags); end
      checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL add_error: got %b expected 0", got_err); end
      checks++; if (extra_done !== 0) begin errors++; $display("FAIL add_done_pulse: got %0d extra expected 0", extra_done); end
   endtask

   task automatic test_add_carry();
      logic exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      run_op(4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL addc_result: got %h expected 00000000", result); end
      checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL addc_flags: got %b expected 0011", flags); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (seq_cin[i] !== exp_c[i]) begin errors++; $display("FAIL addc_iflag_w%0d: got %b expected %b", i, seq_cin[i], exp_c[i]); end
      end
   endtask

   task automatic test_sub();
      logic [3:0] exp_f [4] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010};
      logic       exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      run_op(4'b0001, 32'h00000100, 32'h00000001, 1'b1, 1'b0);
      checks++; if (result !== 32'h000000FF) begin errors++; $display("FAIL sub_result: got %h expected 000000FF", result); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL sub_flags: got %b expected 0010", flags); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL sub_latency: got %0d expected 9", lat); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (seq_func[i] !== exp_f[i]) begin errors++; $display("FAIL sub_func_w%0d: got %b expected %b", i, seq_func[i], exp_f[i]); end
         checks++; if (seq_cin[i] !== exp_c[i]) begin errors++; $display("FAIL sub_iflag_w%0d: got %b expected %b", i, seq_cin[i], exp_c[i]); end
      end
   endtask

   task automatic test_unsupported();
      run_op(4'b0111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
      checks++; if (lat !== 1) begin errors++; $display("FAIL unsup_latency: got %0d expected 1", lat); end
      checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL unsup_error: got %b expected 1", got_err); end
      checks++; if (n_cap !== 0) begin errors++; $display("FAIL unsup_oe: got %0d low cycles expected 0", n_cap); end
      checks++; if (result !== 32'h000000FF || flags !== 4'b0010) begin errors++; $display("FAIL unsup_hold: got %h/%b expected 000000FF/0010", result, flags); end
      checks++; if (extra_done !== 0) begin errors++; $display("FAIL unsup_done_pulse: got %0d extra expected 0", extra_done); end
   endtask

   task automatic test_xor();
      run_op(4'b0110, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, 1'b0);
      checks++; if (result !== 32'h5A5AA5A5) begin errors++; $display("FAIL xor_result: got %h expected 5A5AA5A5", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL xor_flags: got %b expected 0000", flags); end
      checks++; if (n_cap !== 4) begin errors++; $display("FAIL xor_oe_low: got %0d cycles expected 4", n_cap); end
      checks++; if (alu_oe !== 1'b1) begin errors++; $display("FAIL xor_oe_idle: got %b expected 1", alu_oe); end
   endtask

   task automatic test_logic_ops();
      run_op(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0);
      checks++; if (result !== 32'hF000F000 || flags !== 4'b0100) begin errors++; $display("FAIL and_op: got %h/%b expected F000F000/0100", result, flags); end
      run_op(4'b0100, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0);
      checks++; if (result !== 32'h000000FF || flags !== 4'b0000) begin errors++; $display("FAIL or_op: got %h/%b expected 000000FF/0000", result, flags); end
      run_op(4'b0101, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0);
      checks++; if (result !== 32'h00000000 || flags !== 4'b0001) begin errors++; $display("FAIL not_op: got %h/%b expected 00000000/0001", result, flags); end
   endtask

   task automatic test_back_to_back();
      run_op(4'b0000, 32'h12345678, 32'h11111111, 1'b0, 1'b1);
      checks++; if (result !== 32'h23456789) begin errors++; $display("FAIL busy_start_result: got %h expected 23456789", result); end
      checks++; if (lat !== 9 || got_err !== 1'b0) begin errors++; $display("FAIL busy_start_done: got lat %0d err %b expected 9/0", lat, got_err); end
      checks++; if (extra_done !== 0) begin errors++; $display("FAIL busy_start_extra: got %0d extra expected 0", extra_done); end
   endtask

   task automatic test_reset_mid();
      int late_done;
      @(negedge clk);
      op = 4'b0000; op_a = 32'h12345678; op_b = 32'h01010101; carry_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (alu_oe !== 1'b0) begin errors++; $display("FAIL midrst_in_capture: got oe %b expected 0", alu_oe); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || alu_oe !== 1'b1) begin errors++; $display("FAIL midrst_async: got busy %b oe %b expected 0/1", busy, alu_oe); end
      checks++; if (result !== 32'd0 || alu_a !== 8'd0) begin errors++; $display("FAIL midrst_clear: got %h/%h expected 0/0", result, alu_a); end
      @(negedge clk);
      rst_n = 1'b1;
      late_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      checks++; if (late_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles expected 0", late_done); end
      run_op(4'b0000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
      checks++; if (result !== 32'h00000002 || lat !== 9) begin errors++; $display("FAIL midrst_restart: got %h lat %0d expected 00000002/9", result, lat); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_add_carry();
      test_sub();
      test_unsupported();
      test_xor();
      test_logic_ops();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
